// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the OTTER program-counter generator.
// Imported by pc_gen and pc_gen_tgt_sel.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_JALR   = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JAL    = 3'd3,
        SEL_MTVEC  = 3'd4,
        SEL_MEPC   = 3'd5
    } pc_sel_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_t;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Reserved encodings 6/7 behave like SEQ, so they are never a redirect.
    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel != SEL_SEQ) && (sel <= SEL_MEPC);
    endfunction

endpackage

// File: rtl/pc_gen_tgt_sel.sv
// Combinational next-PC target select: JALR LSB clear, mtvec vectoring, alignment.
// With PC_MISALIGN_CHK_EN the raw target is passed through and flagged instead of masked.
module pc_gen_tgt_sel
    import pc_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4,
    parameter int CW     = 4
) (
    input  logic [2:0]      sel_i,
    input  logic [XLEN-1:0] pc_seq_i,
    input  logic [XLEN-1:0] jalr_i,
    input  logic [XLEN-1:0] branch_i,
    input  logic [XLEN-1:0] jal_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [CW-1:0]   cause_i,
    input  logic            intr_i,
`ifdef PC_MISALIGN_CHK_EN
    output logic            misalign_o,
`endif
    output logic [XLEN-1:0] tgt_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(IALIGN - 1);

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] mtvec_base;

    always_comb begin
        mtvec_base = {mtvec_i[XLEN-1:2], 2'b00};
        raw        = pc_seq_i;
        case (sel_i)
            SEL_JALR:   raw = {jalr_i[XLEN-1:1], 1'b0};
            SEL_BRANCH: raw = branch_i;
            SEL_JAL:    raw = jal_i;
            SEL_MTVEC: begin
                // Only interrupts are vectored; synchronous exceptions use the base.
                if (mtvec_i[1:0] == MTVEC_VECTORED && intr_i)
                    raw = mtvec_base + (XLEN'(cause_i) << 2);
                else
                    raw = mtvec_base;
            end
            SEL_MEPC:   raw = mepc_i;
            default:    raw = pc_seq_i;
        endcase
    end

`ifdef PC_MISALIGN_CHK_EN
    assign tgt_o      = raw;
    assign misalign_o = (raw & ~ALIGN_MASK) != '0;
`else
    assign tgt_o      = raw & ALIGN_MASK;
`endif

endmodule

// File: rtl/pc_gen.sv
// OTTER fetch program counter: BOOT/RUN/PEND FSM, held redirect and PC register.
// Optional PC_MISALIGN_CHK_EN adds MISALIGN / MISALIGN_ADDR misaligned-target reporting.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4,
    parameter int              NCAUSE    = 16,
    localparam int             CW        = (NCAUSE > 1) ? $clog2(NCAUSE) : 1
) (
    input  logic            clk,
    input  logic            PC_RST,
    input  logic            PC_WE,
    input  logic [2:0]      PC_SEL,
    input  logic [XLEN-1:0] JALR,
    input  logic [XLEN-1:0] BRANCH,
    input  logic [XLEN-1:0] JAL,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] MEPC,
    input  logic [CW-1:0]   TRAP_CAUSE,
    input  logic            TRAP_INTR,
    input  logic            INSTR_C,
`ifdef PC_MISALIGN_CHK_EN
    output logic            MISALIGN,
    output logic [XLEN-1:0] MISALIGN_ADDR,
`endif
    output logic [XLEN-1:0] PC_COUNT,
    output logic [XLEN-1:0] PC_SEQ,
    output logic            PC_VALID,
    output logic            REDIR_PEND
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] apply_tgt;
    logic            apply;
    logic            redir;

`ifdef PC_MISALIGN_CHK_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(IALIGN - 1);

    logic            tgt_mis;
    logic            pend_mis;
    logic            apply_mis;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    assign pend_mis = (pend_q & ~ALIGN_MASK) != '0;
`endif

    assign step   = (IALIGN == 2 && INSTR_C) ? XLEN'(2) : XLEN'(4);
    assign PC_SEQ = pc_q + step;
    assign redir  = is_redirect(PC_SEL);

    pc_gen_tgt_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN),
        .CW     (CW)
    ) u_tgt_sel (
        .sel_i      (PC_SEL),
        .pc_seq_i   (PC_SEQ),
        .jalr_i     (JALR),
        .branch_i   (BRANCH),
        .jal_i      (JAL),
        .mtvec_i    (MTVEC),
        .mepc_i     (MEPC),
        .cause_i    (TRAP_CAUSE),
        .intr_i     (TRAP_INTR),
`ifdef PC_MISALIGN_CHK_EN
        .misalign_o (tgt_mis),
`endif
        .tgt_o      (tgt)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        apply     = 1'b0;
        apply_tgt = pc_q;
`ifdef PC_MISALIGN_CHK_EN
        apply_mis  = 1'b0;
        misalign_d = 1'b0;
        maddr_d    = maddr_q;
`endif
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (PC_WE) begin
                    apply     = 1'b1;
                    apply_tgt = tgt;
`ifdef PC_MISALIGN_CHK_EN
                    apply_mis = tgt_mis;
`endif
                end else if (redir) begin
                    pend_d  = tgt;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (PC_WE) begin
                    // A live redirect on the release cycle supersedes the held one.
                    apply     = 1'b1;
                    state_d   = ST_RUN;
                    apply_tgt = redir ? tgt : pend_q;
`ifdef PC_MISALIGN_CHK_EN
                    apply_mis = redir ? tgt_mis : pend_mis;
`endif
                end else if (redir) begin
                    pend_d = tgt;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (apply) begin
`ifdef PC_MISALIGN_CHK_EN
            if (apply_mis) begin
                misalign_d = 1'b1;
                maddr_d    = apply_tgt;
            end else begin
                pc_d = apply_tgt;
            end
`else
            pc_d = apply_tgt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (PC_RST) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
            maddr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
            maddr_q    <= maddr_d;
`endif
        end
    end

    // The held target is only consulted in PEND, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign PC_COUNT   = pc_q;
    assign PC_VALID   = (state_q != ST_BOOT);
    assign REDIR_PEND = (state_q == ST_PEND);
`ifdef PC_MISALIGN_CHK_EN
    assign MISALIGN      = misalign_q;
    assign MISALIGN_ADDR = maddr_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (IALIGN=4 / RESET_VEC=0 and IALIGN=2 / RESET_VEC=0x100)
// checked every cycle against a transaction-level PC model, plus literal pins.
module tb_pc_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, intr, instr_c;
    logic [2:0]  sel;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic [3:0]  cause;

    logic [31:0] pc_o    [2];
    logic [31:0] seq_o   [2];
    logic        valid_o [2];
    logic        pend_o  [2];
`ifdef PC_MISALIGN_CHK_EN
    logic        mis_o   [2];
    logic [31:0] maddr_o [2];
`endif

    int unsigned ialign [2] = '{4, 2};
    logic [31:0] rv     [2] = '{32'h0, 32'h100};

    logic [31:0] m_pc    [2];
    logic        m_boot  [2];
    logic        m_pend  [2];
    logic [31:0] m_ptgt  [2];
    logic        m_mis   [2];
    logic [31:0] m_maddr [2];

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(4), .NCAUSE(16)) dut_a (
        .clk(clk), .PC_RST(rst), .PC_WE(we), .PC_SEL(sel),
        .JALR(jalr), .BRANCH(branch), .JAL(jal), .MTVEC(mtvec), .MEPC(mepc),
        .TRAP_CAUSE(cause), .TRAP_INTR(intr), .INSTR_C(instr_c),
`ifdef PC_MISALIGN_CHK_EN
        .MISALIGN(mis_o[0]), .MISALIGN_ADDR(maddr_o[0]),
`endif
        .PC_COUNT(pc_o[0]), .PC_SEQ(seq_o[0]), .PC_VALID(valid_o[0]), .REDIR_PEND(pend_o[0])
    );

    pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(2), .NCAUSE(16)) dut_b (
        .clk(clk), .PC_RST(rst), .PC_WE(we), .PC_SEL(sel),
        .JALR(jalr), .BRANCH(branch), .JAL(jal), .MTVEC(mtvec), .MEPC(mepc),
        .TRAP_CAUSE(cause), .TRAP_INTR(intr), .INSTR_C(instr_c),
`ifdef PC_MISALIGN_CHK_EN
        .MISALIGN(mis_o[1]), .MISALIGN_ADDR(maddr_o[1]),
`endif
        .PC_COUNT(pc_o[1]), .PC_SEQ(seq_o[1]), .PC_VALID(valid_o[1]), .REDIR_PEND(pend_o[1])
    );

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stepv(input int i);
        return (ialign[i] == 2 && instr_c) ? 32'd2 : 32'd4;
    endfunction

    // Architectural target for the current select, before any redirect/stall handling.
    function automatic logic [31:0] model_tgt(input int i);
        logic [31:0] t;
        case (sel)
            3'd1: t = jalr & ~32'd1;
            3'd2: t = branch;
            3'd3: t = jal;
            3'd4: begin
                t = mtvec & ~32'd3;
                if (mtvec[1:0] == 2'b01 && intr) t = t + 32'(cause) * 4;
            end
            3'd5: t = mepc;
            default: t = m_pc[i] + stepv(i);
        endcase
`ifndef PC_MISALIGN_CHK_EN
        t = t - (t % ialign[i]);
`endif
        return t;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] t, nt;
            logic        redir;
            t     = model_tgt(i);
            redir = (sel >= 3'd1 && sel <= 3'd5);
            if (rst) begin
                m_pc[i] = rv[i]; m_boot[i] = 1'b1; m_pend[i] = 1'b0;
                m_mis[i] = 1'b0; m_maddr[i] = 32'h0;
            end else if (m_boot[i]) begin
                m_boot[i] = 1'b0; m_mis[i] = 1'b0;
            end else begin
                m_mis[i] = 1'b0;
                if (we) begin
                    nt = redir ? t : (m_pend[i] ? m_ptgt[i] : t);
                    m_pend[i] = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
                    if (nt % ialign[i] != 0) begin
                        m_mis[i] = 1'b1; m_maddr[i] = nt;
                    end else begin
                        m_pc[i] = nt;
                    end
`else
                    m_pc[i] = nt;
`endif
                end else if (redir) begin
                    m_pend[i] = 1'b1; m_ptgt[i] = t;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [2:0] s);
        rst = r; we = w; sel = s;
        @(posedge clk);
        model_edge();
        #2;
        chk_on = 1'b1;
    endtask

    task automatic pin(input string nm, input int i, input logic [31:0] exp);
        check(nm, i, pc_o[i], exp);
        check({nm, "_model"}, i, m_pc[i], exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check("pc_count", i, pc_o[i], m_pc[i]);
                check("pc_valid", i, 32'(valid_o[i]), 32'(!m_boot[i]));
                check("redir_pend", i, 32'(pend_o[i]), 32'(m_pend[i]));
                check("pc_seq", i, seq_o[i], m_pc[i] + stepv(i));
`ifdef PC_MISALIGN_CHK_EN
                check("misalign", i, 32'(mis_o[i]), 32'(m_mis[i]));
                check("misalign_addr", i, maddr_o[i], m_maddr[i]);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; sel = 3'd0; intr = 1'b0; instr_c = 1'b0;
        jalr = '0; branch = '0; jal = '0; mtvec = '0; mepc = '0; cause = '0;
        @(negedge clk);

        // Reset, boot cycle, then sequential stepping
        cyc(1, 1, 0); cyc(1, 1, 0);
        pin("reset_pc", 0, 32'h0); pin("reset_pc", 1, 32'h100);
        check("reset_valid_lit", 0, 32'(valid_o[0]), 32'd0);
        cyc(0, 1, 0); pin("boot_pc", 0, 32'h0);
        check("run_valid_lit", 0, 32'(valid_o[0]), 32'd1);
        cyc(0, 1, 0); pin("seq4", 0, 32'h4);
        cyc(0, 1, 0); pin("seq8", 0, 32'h8);
        cyc(0, 1, 0); pin("seq12", 0, 32'hC);

        // Compressed stepping on the IALIGN=2 instance
        jal = 32'h100; cyc(0, 1, 3); pin("jal100", 1, 32'h100);
        instr_c = 1'b1; cyc(0, 1, 0); pin("c_step", 1, 32'h102); pin("c_ign", 0, 32'h104);
        instr_c = 1'b0; cyc(0, 1, 0); pin("w_step", 1, 32'h106);

        // Stall with redirects, newest wins, released with SEQ
        branch = 32'h200; cyc(0, 0, 2);
        check("pend_lit", 0, 32'(pend_o[0]), 32'd1);
        jal = 32'h300; cyc(0, 0, 3);
        cyc(0, 1, 0); pin("pend_rel", 0, 32'h300);
        check("pend_clr_lit", 0, 32'(pend_o[0]), 32'd0);
        cyc(0, 0, 0); pin("stall_hold", 0, 32'h300);
        cyc(0, 0, 6); check("rsv_no_pend", 0, 32'(pend_o[0]), 32'd0);

        // Live redirect beats pending one
        branch = 32'h200; cyc(0, 0, 2);
        mepc = 32'h500; cyc(0, 1, 5); pin("live_wins", 0, 32'h500);

        // mtvec vectoring
        mtvec = 32'h1001; intr = 1'b1; cause = 4'd7;
        cyc(0, 1, 4); pin("mtvec_vec", 0, 32'h101C);
        intr = 1'b0; cyc(0, 1, 4); pin("mtvec_exc", 0, 32'h1000);
        mtvec = 32'h1003; intr = 1'b1; cyc(0, 1, 4); pin("mtvec_mode3", 1, 32'h1000);
        intr = 1'b0;

        // JALR LSB clear, reserved select, wrap
        jalr = 32'h405; cyc(0, 1, 1); pin("jalr", 0, 32'h404);
        cyc(0, 1, 7); pin("sel7", 0, 32'h408);
        jal = 32'hFFFF_FFFC; cyc(0, 1, 3); pin("pre_wrap", 0, 32'hFFFF_FFFC);
        cyc(0, 1, 0); pin("wrap", 0, 32'h0); pin("wrap", 1, 32'h0);

        // Misaligned target
        jal = 32'h402; cyc(0, 1, 3);
`ifdef PC_MISALIGN_CHK_EN
        pin("misal_hold", 0, 32'h0);
        check("misal_lit", 0, 32'(mis_o[0]), 32'd1);
        check("misal_addr_lit", 0, maddr_o[0], 32'h402);
        cyc(0, 0, 0); check("misal_pulse", 0, 32'(mis_o[0]), 32'd0);
`else
        pin("misal_mask", 0, 32'h400);
`endif
        pin("ok_ialign2", 1, 32'h402);

        // Reset while pending discards the held target
        branch = 32'h700; cyc(0, 0, 2);
        cyc(1, 0, 0); pin("rst_pend", 0, 32'h0);
        check("rst_pend_lit", 0, 32'(pend_o[0]), 32'd0);
        cyc(0, 1, 0); cyc(0, 1, 0); pin("after_rst", 0, 32'h4); pin("after_rst", 1, 32'h104);

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
